// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM states, default
// frame geometry and the RGB565 -> RGB332 pixel packing.
package cam_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_BYTE_HI,
    ST_BYTE_LO,
    ST_DONE
  } cam_state_t;

  // hi = {R4..R0,G5..G3}, lo = {G2..G0,B4..B0}; keep the top bits of each colour
  function automatic logic [7:0] pack_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/rgb565_to_332.sv
// Combinational RGB565 byte pair to RGB332 pixel converter.
module rgb565_to_332
  import cam_pkg::*;
(
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  output logic [7:0] pixel
);

  // Pure repacking, no state
  always_comb begin
    pixel = pack_rgb332(hi, lo);
  end

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: samples the camera bus on pixel-clock strobes,
// assembles RGB565 byte pairs into RGB332 pixels and writes them
// sequentially into a frame buffer, one frame per enabled vsync.
module cam_capture
  import cam_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk_pulse,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        px_data,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  cam_state_t  state;
  logic [7:0]  hi_byte;
  logic [7:0]  pixel;
  logic        addr_full;

  rgb565_to_332 u_pack (
    .hi    (hi_byte),
    .lo    (px_data),
    .pixel (pixel)
  );

  // Frame FSM with registered outputs; the address advances the cycle after
  // each write so it stays stable while mem_wr is high, and freezes once the
  // last buffer location has been written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hi_byte    <= '0;
      addr_full  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;

      if (mem_wr && !addr_full) begin
        mem_addr <= mem_addr + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pclk_pulse && vsync && capture_en) begin
            state <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (pclk_pulse && !vsync) begin
            state     <= ST_BYTE_HI;
            mem_addr  <= '0;
            overflow  <= 1'b0;
            addr_full <= 1'b0;
            busy      <= 1'b1;
          end
        end

        ST_BYTE_HI: begin
          if (pclk_pulse) begin
            if (vsync) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else if (href) begin
              hi_byte <= px_data;
              state   <= ST_BYTE_LO;
            end
          end
        end

        ST_BYTE_LO: begin
          if (pclk_pulse) begin
            if (vsync) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state <= ST_BYTE_HI;
              if (href) begin
                if (!addr_full) begin
                  mem_wr   <= 1'b1;
                  mem_data <= pixel;
                  if (mem_addr == LAST_ADDR) begin
                    addr_full <= 1'b1;
                  end
                end else begin
                  overflow <= 1'b1;
                end
              end
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed self-checking bench for cam_capture using a small 4x2 frame so the
// address bound and overflow behaviour are reachable quickly.
module tb_cam_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        pclk_pulse;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic        capture_en;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        frame_done;
  logic        busy;
  logic        overflow;

  int compared_count = 0;
  int mismatch_count = 0;

  cam_capture #(
    .IMG_W  (4),
    .IMG_H  (2),
    .ADDR_W (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pclk_pulse (pclk_pulse),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .capture_en (capture_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // One pixel-clock strobe, driven at a falling edge; returns at the next
  // falling edge, where the registered response to that sample is visible.
  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    pclk_pulse = 1'b1;
    vsync      = vs;
    href       = hr;
    px_data    = d;
    @(negedge clk);
    pclk_pulse = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared_count++;
    assert (observed === expected) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // hi byte, gap, lo byte; returns where the write (if any) is visible
  task automatic sendPixel(input logic [7:0] hi, input logic [7:0] lo);
    applyStimulus(1'b0, 1'b1, hi);
    idleCycle();
    applyStimulus(1'b0, 1'b1, lo);
  endtask

  task automatic expectWrite(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] exp_data, input logic [14:0] exp_addr);
    sendPixel(hi, lo);
    checkOutput({tag, "_wr"},   32'(mem_wr),   32'd1);
    checkOutput({tag, "_data"}, 32'(mem_data), 32'(exp_data));
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    idleCycle();
    checkOutput({tag, "_wr_off"}, 32'(mem_wr), 32'd0);
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 8'h00);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00);
    idleCycle();
  endtask

  initial begin
    rst        = 1'b1;
    pclk_pulse = 1'b0;
    vsync      = 1'b0;
    href       = 1'b0;
    px_data    = 8'h00;
    capture_en = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_addr",  32'(mem_addr),   32'd0);
    checkOutput("rst_data",  32'(mem_data),   32'd0);
    checkOutput("rst_wr",    32'(mem_wr),     32'd0);
    checkOutput("rst_done",  32'(frame_done), 32'd0);
    checkOutput("rst_busy",  32'(busy),       32'd0);
    checkOutput("rst_ovf",   32'(overflow),   32'd0);
    rst = 1'b0;
    idleCycle();

    // Frame 1: one line of red pixels, colour vectors, misaligned end, overflow
    $display("[TB] frame 1: basic capture and address bound");
    capture_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("sync_busy", 32'(busy), 32'd0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("start_busy", 32'(busy),     32'd1);
    checkOutput("start_addr", 32'(mem_addr), 32'd0);
    idleCycle();
    expectWrite("red0", 8'hF8, 8'h00, 8'hE0, 15'd0);
    expectWrite("red1", 8'hF8, 8'h00, 8'hE0, 15'd1);
    expectWrite("red2", 8'hF8, 8'h00, 8'hE0, 15'd2);
    expectWrite("red3", 8'hF8, 8'h00, 8'hE0, 15'd3);
    applyStimulus(1'b0, 1'b0, 8'h00);
    idleCycle();
    expectWrite("cyan", 8'h07, 8'hFF, 8'h1F, 15'd4);
    expectWrite("blue", 8'h00, 8'h1F, 8'h03, 15'd5);

    applyStimulus(1'b0, 1'b1, 8'hAA);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h55);
    checkOutput("misalign_wr", 32'(mem_wr), 32'd0);
    idleCycle();
    checkOutput("misalign_addr", 32'(mem_addr), 32'd6);
    expectWrite("mix0", 8'h12, 8'h34, 8'h0A, 15'd6);
    expectWrite("mix1", 8'hE0, 8'h18, 8'hE3, 15'd7);
    checkOutput("full_ovf0", 32'(overflow), 32'd0);
    checkOutput("full_addr", 32'(mem_addr), 32'd7);

    sendPixel(8'hF8, 8'h00);
    checkOutput("ovf_wr",   32'(mem_wr),   32'd0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_addr", 32'(mem_addr), 32'd7);
    idleCycle();

    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("end_done", 32'(frame_done), 32'd1);
    checkOutput("end_busy", 32'(busy),       32'd0);
    checkOutput("end_ovf",  32'(overflow),   32'd1);
    idleCycle();
    checkOutput("end_done_off", 32'(frame_done), 32'd0);

    // Capture disabled through vsync, enabled mid-frame: nothing captured
    $display("[TB] capture_en gating");
    capture_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("gated_busy", 32'(busy), 32'd0);
    idleCycle();
    capture_en = 1'b1;
    sendPixel(8'hF8, 8'h00);
    checkOutput("gated_wr",   32'(mem_wr), 32'd0);
    checkOutput("gated_busy2", 32'(busy),  32'd0);
    idleCycle();

    // Next vsync starts a fresh frame; it ends with zero pixels
    $display("[TB] zero-pixel frame");
    startFrame();
    checkOutput("z_busy", 32'(busy),     32'd1);
    checkOutput("z_ovf",  32'(overflow), 32'd0);
    checkOutput("z_addr", 32'(mem_addr), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("z_done", 32'(frame_done), 32'd1);
    checkOutput("z_addr_end", 32'(mem_addr), 32'd0);
    idleCycle();

    // Asynchronous reset in the middle of a line
    $display("[TB] reset mid-line");
    startFrame();
    expectWrite("pre_rst", 8'h07, 8'hFF, 8'h1F, 15'd0);
    applyStimulus(1'b0, 1'b1, 8'hF8);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_data", 32'(mem_data), 32'd0);
    checkOutput("arst_busy", 32'(busy),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle();
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("post_rst_wr", 32'(mem_wr), 32'd0);
    idleCycle();
    sendPixel(8'hF8, 8'h00);
    checkOutput("post_rst_wr2", 32'(mem_wr), 32'd0);
    checkOutput("post_rst_busy", 32'(busy),  32'd0);
    idleCycle();
    startFrame();
    expectWrite("after_sync", 8'hF8, 8'h00, 8'hE0, 15'd0);
    expectWrite("after_sync1", 8'h00, 8'h1F, 8'h03, 15'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
# cam_capture

Downstream of the pixel-clock edge detector. Consumes its one-cycle `pclk_pulse` strobe together with the camera's `vsync`, `href` and 8-bit data bus, all in the system `clk` domain. Assembles RGB565 byte pairs into RGB332 pixels and writes them sequentially into a frame-buffer port, one write per pixel. Frames are gated by a capture enable, bounded by vsync, and overflow-protected.

## Interface
- `IMG_W`, 160: pixels per line, used only for the address bound.
- `IMG_H`, 120: lines per frame.
- `ADDR_W`, 15: frame-buffer address width. Must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pclk_pulse` input 1: one-`clk` strobe marking a camera pixel-clock rising edge.
- `vsync` input 1: camera frame sync, high between frames.
- `href` input 1: camera line valid.
- `px_data` input 8: camera data byte.
- `capture_en` input 1: level; permits a new frame to start.
- `mem_addr` output ADDR_W: write address.
- `mem_data` output 8: RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- `mem_wr` output 1: one-cycle write strobe.
- `frame_done` output 1: one-cycle pulse at end of a captured frame.
- `busy` output 1: high while a frame is being captured.
- `overflow` output 1: sticky; pixels were dropped in the current or last frame.

## Operation
- `vsync`, `href` and `px_data` are sampled only in cycles where `pclk_pulse`=1. All other cycles are ignored for input decisions.
- States:
  - IDLE: wait for a sampled `vsync`=1 with `capture_en`=1, then go to SYNC.
  - SYNC: wait for sampled `vsync`=0, then go to BYTE_HI. On that transition: `mem_addr`←0, `overflow`←0, `busy`←1.
  - BYTE_HI: on a sample with `href`=1, latch `px_data` as the high byte and go to BYTE_LO. On a sample with `vsync`=1, go to DONE.
  - BYTE_LO: on a sample with `href`=1, form and write the pixel, then return to BYTE_HI. On a sample with `href`=0, discard the high byte and return to BYTE_HI (misaligned line end). On a sample with `vsync`=1, go to DONE.
  - DONE: one cycle. `frame_done`=1, `busy`←0, go to IDLE.
- Pixel packing:
  - hi byte = {R4..R0,G5..G3}; lo byte = {G2..G0,B4..B0}.
  - `mem_data` = {hi[7:5], hi[2:0], lo[4:3]}.
- Address handling:
  - `mem_addr` presents the address of the current write. It increments by 1 in the cycle after each write.
  - At the write to address IMG_W·IMG_H−1, the address holds.
  - Further pixels in the same frame are not written (`mem_wr` stays 0) and set `overflow`.
- `capture_en` is checked only in IDLE. Deasserting it mid-frame does not abort the frame.
- Reset mid-frame returns to IDLE with all outputs cleared. The next capture requires a full vsync high→low sequence.

## Timing
- Reset values: `mem_addr`=0, `mem_data`=0, `mem_wr`=0, `frame_done`=0, `busy`=0, `overflow`=0, state IDLE.
- `mem_wr` and `mem_data` are registered. They assert in the cycle after the `pclk_pulse` that sampled the low byte, so latency is 1 `clk`.
- `mem_addr` is stable during `mem_wr`.
- `frame_done` asserts exactly 1 `clk` after the `pclk_pulse` that sampled `vsync`=1 in BYTE_HI or BYTE_LO. `busy` falls in that same cycle.
- Consecutive `pclk_pulse` strobes can be as close as 2 `clk` apart. All decisions complete within one `clk`.
- A zero-pixel frame (vsync rises before any href) still produces `frame_done`, with `mem_addr`=0.

## Structure
- Shared package `cam_pkg`:
  - state enumeration (IDLE, SYNC, BYTE_HI, BYTE_LO, DONE);
  - default IMG_W/IMG_H constants;
  - RGB565→RGB332 packing function.
- One natural sub-module: `rgb565_to_332`, combinational, taking two bytes in and producing 8 bits out. It is instantiated once. The FSM, address counter and flags live in the top.

## Test plan
- Reset release, then `vsync` pulse with `capture_en`=1, then 1 line of 4 pixels with hi=0xF8, lo=0x00 → 4 writes of 0xE0 at addresses 0..3, each 1 `clk` after its low-byte pulse. Trailing vsync → `frame_done` pulse with `busy` falling.
- Pixel hi=0x07, lo=0xFF → `mem_data`=0x1F. Pixel hi=0x00, lo=0x1F → `mem_data`=0x03.
- IMG_W=4, IMG_H=2, 3 lines × 4 pixels → writes to addresses 0..7 only, `overflow`=1 after the 9th pixel, `mem_addr` holds at 7.
- `href` drops after a single hi byte → no write. The next full pixel is written at the unchanged address.
- `capture_en`=0 during vsync → no writes, `busy` stays 0. Assert `capture_en` mid-frame → capture starts only at the next vsync.
- Assert `rst` mid-line → all outputs 0 immediately (asynchronous). No writes until a full new vsync high→low sequence.
